// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared FSM state type and instruction-word field positions for core_sequencer
package core_seq_pkg;
  typedef enum logic [2:0] {IDLE, WR_K, WR_Q, LOAD_K, EXEC, DRAIN, OUT, DONE} state_e;
  localparam int OFIFO_RD = 16;
  localparam int EXECUTE = 7;
  localparam int LOAD = 6;
  localparam int QMEM_RD = 5;
  localparam int QMEM_WR = 4;
  localparam int KMEM_RD = 3;
  localparam int KMEM_WR = 2;
  localparam int PMEM_RD = 1;
  localparam int PMEM_WR = 0;
  localparam int QK_ADD_LSB = 12;
  localparam int P_ADD_LSB = 8;
endpackage

// File: rtl/core_sequencer_inst_enc.sv
// seq_inst_enc: combinational map from sequencer state and counter to the 17-bit core instruction
module seq_inst_enc
  import core_seq_pkg::*;
#(
  parameter int col = 8
) (
  input  state_e      state_i,
  input  logic [4:0]  cnt_i,
  output logic [16:0] inst_o
);
  logic [16:0] qk, pa;
  assign qk = 17'(cnt_i[3:0]) << QK_ADD_LSB;
  assign pa = 17'(cnt_i[3:0]) << P_ADD_LSB;
  always_comb begin
    inst_o = '0;
    case (state_i)
      WR_K:    inst_o = (17'd1 << KMEM_WR) | qk;
      WR_Q:    inst_o = (17'd1 << QMEM_WR) | qk;
      LOAD_K:  inst_o = (cnt_i < 5'(col)) ? ((17'd1 << KMEM_RD) | (17'd1 << LOAD) | qk) : '0;
      EXEC:    inst_o = (17'd1 << QMEM_RD) | (17'd1 << EXECUTE) | qk;
      OUT:     inst_o = (17'd1 << OFIFO_RD) | (17'd1 << PMEM_WR) | pa;
      default: inst_o = '0;
    endcase
  end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: sequences one attention-score pass (load K/Q, load, execute, drain, retire); SEQ_PERF_EN adds cycle_cnt
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int col   = 8,
  parameter int bw    = 8,
  parameter int pr    = 8,
  parameter int drain = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       n_q,
  input  logic [pr*bw-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [pr*bw-1:0] mem_out,
  output logic [16:0]      inst_out,
  output logic             busy,
  output logic             done
`ifdef SEQ_PERF_EN
  ,
  output logic [15:0]      cycle_cnt
`endif
);
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d, nq_q, nq_d;
  logic [16:0] inst_q, inst_d, enc_inst;
  logic [pr*bw-1:0] mem_q;
  logic xfer, q_last;

  seq_inst_enc #(.col(col)) u_enc (.state_i(state_q), .cnt_i(cnt_q), .inst_o(enc_inst));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nq_q    <= '0;
      inst_q  <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      inst_q  <= inst_d;
      if (xfer) mem_q <= data_in;
    end
  end

  assign q_last = cnt_q == nq_q - 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    nq_d    = nq_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          nq_d    = (n_q > 5'd16) ? 5'd16 : n_q;
          state_d = (n_q == 5'd0) ? DONE : WR_K;
        end
      end
      WR_K: begin
        if (!xfer) cnt_d = cnt_q;
        else if (cnt_q == 5'(col - 1)) begin
          state_d = WR_Q;
          cnt_d   = '0;
        end
      end
      WR_Q: begin
        if (!xfer) cnt_d = cnt_q;
        else if (q_last) begin
          state_d = LOAD_K;
          cnt_d   = '0;
        end
      end
      // cnt == col is the single idle cycle between the K load and the first execute
      LOAD_K: begin
        if (cnt_q == 5'(col)) begin
          state_d = EXEC;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        if (q_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == 5'(drain - 1)) begin
          state_d = OUT;
          cnt_d   = '0;
        end
      end
      OUT: begin
        if (q_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_ready = (state_q == WR_K) || (state_q == WR_Q);
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    xfer       = data_ready && data_valid;
    inst_d     = (data_ready && !data_valid) ? '0 : enc_inst;
  end

  assign inst_out = inst_q;
  assign mem_out  = mem_q;

`ifdef SEQ_PERF_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else if (state_q == IDLE && start) cyc_q <= '0;
    else if (busy && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
  end
  assign cycle_cnt = cyc_q;
`endif
endmodule
